// File: rtl/data_req_ctrl_if.sv
// Data-memory request/response bus (SRAM-like handshake).
// master: the request controller; slave: the data memory.
//   data_req/wr/size/addr/wstrb/wdata : request channel, held while data_req is high
//   data_addr_ok                      : request accepted this cycle
//   data_data_ok/data_rdata           : response (or write-ack) this cycle
interface data_req_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_req_ctrl.sv
// Data-side memory request controller at the EX->MEM boundary.
// Checks alignment, builds strobes and lane-aligned store data, runs the
// request/response handshake and stalls the front of the pipe until done.
//   clk, rst            : clock, synchronous active-high reset
//   ex_*                : load/store op presented by EX
//   flush, pipe_stall   : pipeline flush, stall from other sources
//   mem                 : data-memory bus (master side)
//   ls_stall            : hold IF/ID/EX (combinational)
//   data_ram_rdata      : captured read word for the MEM stage
//   is_data_adel/ades   : load/store address error (combinational)
`ifndef LS_SEL_LB
`define LS_SEL_LB  4'd0
`define LS_SEL_LBU 4'd1
`define LS_SEL_LH  4'd2
`define LS_SEL_LHU 4'd3
`define LS_SEL_LW  4'd4
`define LS_SEL_LWL 4'd5
`define LS_SEL_LWR 4'd6
`define LS_SEL_SB  4'd8
`define LS_SEL_SH  4'd9
`define LS_SEL_SW  4'd10
`define LS_SEL_SWL 4'd11
`define LS_SEL_SWR 4'd12
`endif

module data_req_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_ls_ena,
    input  logic [3:0]             ex_ls_sel,
    input  logic [31:0]            ex_ls_addr,
    input  logic [31:0]            ex_rt_data,
    input  logic                   ex_has_exception,
    input  logic                   flush,
    input  logic                   pipe_stall,
    data_req_ctrl_if.master        mem,
    output logic                   ls_stall,
    output logic [31:0]            data_ram_rdata,
    output logic                   is_data_adel,
    output logic                   is_data_ades
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_next;
    logic        killed, killed_next;
    logic        wr_q, wr_next;
    logic [1:0]  size_q, size_next;
    logic [31:0] addr_q, addr_next;
    logic [3:0]  strb_q, strb_next;
    logic [31:0] wdata_q, wdata_next;
    logic [31:0] rdata_next;

    logic        is_load, is_store, misalign;
    logic [1:0]  op_size;
    logic [31:0] op_addr;
    logic [3:0]  op_strb;
    logic [31:0] op_wdata;
    logic        start;

    // Decode the EX op into request fields, strobes and alignment check
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        op_size  = 2'd2;
        op_addr  = {ex_ls_addr[31:2], 2'b00};
        op_strb  = 4'b0000;
        op_wdata = 32'h0;
        case (ex_ls_sel)
            `LS_SEL_LB, `LS_SEL_LBU: begin
                is_load = 1'b1;
                op_size = 2'd0;
                op_addr = ex_ls_addr;
            end
            `LS_SEL_LH, `LS_SEL_LHU: begin
                is_load  = 1'b1;
                op_size  = 2'd1;
                op_addr  = ex_ls_addr;
                misalign = ex_ls_addr[0];
            end
            `LS_SEL_LW: begin
                is_load  = 1'b1;
                misalign = |ex_ls_addr[1:0];
            end
            `LS_SEL_LWL, `LS_SEL_LWR: is_load = 1'b1;
            `LS_SEL_SB: begin
                is_store = 1'b1;
                op_size  = 2'd0;
                op_addr  = ex_ls_addr;
                op_strb  = 4'b0001 << ex_ls_addr[1:0];
                op_wdata = {4{ex_rt_data[7:0]}};
            end
            `LS_SEL_SH: begin
                is_store = 1'b1;
                op_size  = 2'd1;
                op_addr  = ex_ls_addr;
                misalign = ex_ls_addr[0];
                op_strb  = ex_ls_addr[1] ? 4'b1100 : 4'b0011;
                op_wdata = {2{ex_rt_data[15:0]}};
            end
            `LS_SEL_SW: begin
                is_store = 1'b1;
                misalign = |ex_ls_addr[1:0];
                op_strb  = 4'b1111;
                op_wdata = ex_rt_data;
            end
            `LS_SEL_SWL: begin
                is_store = 1'b1;
                case (ex_ls_addr[1:0])
                    2'd0: begin op_strb = 4'b0001; op_wdata = {24'h0, ex_rt_data[31:24]}; end
                    2'd1: begin op_strb = 4'b0011; op_wdata = {16'h0, ex_rt_data[31:16]}; end
                    2'd2: begin op_strb = 4'b0111; op_wdata = {8'h0, ex_rt_data[31:8]}; end
                    default: begin op_strb = 4'b1111; op_wdata = ex_rt_data; end
                endcase
            end
            `LS_SEL_SWR: begin
                is_store = 1'b1;
                case (ex_ls_addr[1:0])
                    2'd0: begin op_strb = 4'b1111; op_wdata = ex_rt_data; end
                    2'd1: begin op_strb = 4'b1110; op_wdata = {ex_rt_data[23:0], 8'h0}; end
                    2'd2: begin op_strb = 4'b1100; op_wdata = {ex_rt_data[15:0], 16'h0}; end
                    default: begin op_strb = 4'b1000; op_wdata = {ex_rt_data[7:0], 24'h0}; end
                endcase
            end
            default: ;
        endcase
    end

    // Address errors follow the EX op directly; quiet while in reset
    assign is_data_adel = !rst && ex_ls_ena && is_load  && misalign;
    assign is_data_ades = !rst && ex_ls_ena && is_store && misalign;

    // Only a clean, aligned op launches a request
    assign start = ex_ls_ena && !ex_has_exception && !flush && (state == S_IDLE)
                   && (is_load || is_store) && !misalign;

    // Next-state, field capture and stall generation
    always_comb begin
        state_next  = state;
        killed_next = killed;
        wr_next     = wr_q;
        size_next   = size_q;
        addr_next   = addr_q;
        strb_next   = strb_q;
        wdata_next  = wdata_q;
        rdata_next  = data_ram_rdata;
        ls_stall    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_REQ;
                    ls_stall   = 1'b1;
                    wr_next    = is_store;
                    size_next  = op_size;
                    addr_next  = op_addr;
                    strb_next  = op_strb;
                    wdata_next = op_wdata;
                end
            end
            S_REQ: begin
                ls_stall = 1'b1;
                if (flush) killed_next = 1'b1;
                if (mem.data_addr_ok) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem.data_data_ok) begin
                    // A flush arriving with the response kills it just the same
                    if (killed || flush) begin
                        state_next = S_IDLE;
                    end else begin
                        if (!wr_q) rdata_next = mem.data_rdata;
                        state_next = pipe_stall ? S_HOLD : S_IDLE;
                    end
                end else begin
                    ls_stall = 1'b1;
                    if (flush) killed_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (!pipe_stall) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (state_next == S_IDLE) killed_next = 1'b0;
        if (rst) ls_stall = 1'b0;
    end

    // State and request-field registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            killed         <= 1'b0;
            wr_q           <= 1'b0;
            size_q         <= 2'd0;
            addr_q         <= 32'h0;
            strb_q         <= 4'h0;
            wdata_q        <= 32'h0;
            data_ram_rdata <= 32'h0;
        end else begin
            state          <= state_next;
            killed         <= killed_next;
            wr_q           <= wr_next;
            size_q         <= size_next;
            addr_q         <= addr_next;
            strb_q         <= strb_next;
            wdata_q        <= wdata_next;
            data_ram_rdata <= rdata_next;
        end
    end

    assign mem.data_req   = (state == S_REQ);
    assign mem.data_wr    = wr_q;
    assign mem.data_size  = size_q;
    assign mem.data_addr  = addr_q;
    assign mem.data_wstrb = strb_q;
    assign mem.data_wdata = wdata_q;

endmodule

// File: tb/tb_data_req_ctrl.sv
// Directed bench for data_req_ctrl; the bench plays the data memory.
module tb_data_req_ctrl;

    localparam logic [3:0] LB  = 4'd0;
    localparam logic [3:0] LBU = 4'd1;
    localparam logic [3:0] LH  = 4'd2;
    localparam logic [3:0] LHU = 4'd3;
    localparam logic [3:0] LW  = 4'd4;
    localparam logic [3:0] LWR = 4'd6;
    localparam logic [3:0] SB  = 4'd8;
    localparam logic [3:0] SH  = 4'd9;
    localparam logic [3:0] SW  = 4'd10;
    localparam logic [3:0] SWL = 4'd11;
    localparam logic [3:0] SWR = 4'd12;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_ls_ena;
    logic [3:0]  ex_ls_sel;
    logic [31:0] ex_ls_addr;
    logic [31:0] ex_rt_data;
    logic        ex_has_exception;
    logic        flush;
    logic        pipe_stall;
    logic        ls_stall;
    logic [31:0] data_ram_rdata;
    logic        is_data_adel;
    logic        is_data_ades;

    int n_checks = 0;
    int n_fails  = 0;

    data_req_ctrl_if bus ();

    data_req_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .ex_ls_ena        (ex_ls_ena),
        .ex_ls_sel        (ex_ls_sel),
        .ex_ls_addr       (ex_ls_addr),
        .ex_rt_data       (ex_rt_data),
        .ex_has_exception (ex_has_exception),
        .flush            (flush),
        .pipe_stall       (pipe_stall),
        .mem              (bus),
        .ls_stall         (ls_stall),
        .data_ram_rdata   (data_ram_rdata),
        .is_data_adel     (is_data_adel),
        .is_data_ades     (is_data_ades)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Minimum-latency access: accept c0, addr_ok c1, data_ok c2, check c3
    task automatic run_access(input string tag, input logic [3:0] sel, input logic [31:0] addr,
                              input logic [31:0] rt, input logic [31:0] rdata,
                              input logic exp_wr, input logic [1:0] exp_size,
                              input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_ram);
        ex_ls_ena = 1'b1; ex_ls_sel = sel; ex_ls_addr = addr; ex_rt_data = rt;
        #1;
        check({tag, ".stall_c0"}, 32'(ls_stall), 32'd1);
        check({tag, ".req_c0"}, 32'(bus.data_req), 32'd0);
        step();
        ex_ls_ena = 1'b0; bus.data_addr_ok = 1'b1;
        #1;
        check({tag, ".req"},   32'(bus.data_req), 32'd1);
        check({tag, ".wr"},    32'(bus.data_wr), 32'(exp_wr));
        check({tag, ".size"},  32'(bus.data_size), 32'(exp_size));
        check({tag, ".addr"},  bus.data_addr, exp_addr);
        check({tag, ".wstrb"}, 32'(bus.data_wstrb), 32'(exp_strb));
        if (exp_wr) check({tag, ".wdata"}, bus.data_wdata, exp_wdata);
        check({tag, ".stall_c1"}, 32'(ls_stall), 32'd1);
        step();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = rdata;
        #1;
        check({tag, ".stall_c2"}, 32'(ls_stall), 32'd0);
        step();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'hDEAD_BEEF;
        #1;
        check({tag, ".ram_c3"}, data_ram_rdata, exp_ram);
        check({tag, ".req_c3"}, 32'(bus.data_req), 32'd0);
        check({tag, ".stall_c3"}, 32'(ls_stall), 32'd0);
    endtask

    // Rejected op: errors as given, no stall, no request next cycle
    task automatic run_reject(input string tag, input logic [3:0] sel, input logic [31:0] addr,
                              input logic exc, input logic exp_adel, input logic exp_ades);
        ex_ls_ena = 1'b1; ex_ls_sel = sel; ex_ls_addr = addr; ex_has_exception = exc;
        #1;
        check({tag, ".adel"},  32'(is_data_adel), 32'(exp_adel));
        check({tag, ".ades"},  32'(is_data_ades), 32'(exp_ades));
        check({tag, ".stall"}, 32'(ls_stall), 32'd0);
        step();
        ex_ls_ena = 1'b0; ex_has_exception = 1'b0;
        #1;
        check({tag, ".req"}, 32'(bus.data_req), 32'd0);
    endtask

    // Killed load: flush with addr_ok (fl1) or with data_ok (fl2); data must be dropped
    task automatic run_flush(input string tag, input logic [31:0] addr, input logic fl1,
                             input logic fl2, input logic [31:0] rdata, input logic [31:0] keep);
        ex_ls_ena = 1'b1; ex_ls_sel = LW; ex_ls_addr = addr;
        step();
        ex_ls_ena = 1'b0; bus.data_addr_ok = 1'b1; flush = fl1;
        #1;
        check({tag, ".req"}, 32'(bus.data_req), 32'd1);
        step();
        bus.data_addr_ok = 1'b0; flush = fl2; bus.data_data_ok = 1'b1; bus.data_rdata = rdata;
        #1;
        check({tag, ".stall"}, 32'(ls_stall), 32'd0);
        step();
        flush = 1'b0; bus.data_data_ok = 1'b0;
        #1;
        check({tag, ".ram"}, data_ram_rdata, keep);
        check({tag, ".req_after"}, 32'(bus.data_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ex_ls_ena = 1'b1; ex_ls_sel = LW; ex_ls_addr = 32'h2; ex_rt_data = 32'h0;
        ex_has_exception = 1'b0; flush = 1'b0; pipe_stall = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        repeat (3) step();

        // Reset state; misaligned op must not flag while in reset
        check("rst.adel",  32'(is_data_adel), 32'd0);
        check("rst.stall", 32'(ls_stall), 32'd0);
        check("rst.req",   32'(bus.data_req), 32'd0);
        check("rst.wr",    32'(bus.data_wr), 32'd0);
        check("rst.size",  32'(bus.data_size), 32'd0);
        check("rst.addr",  bus.data_addr, 32'd0);
        check("rst.wstrb", 32'(bus.data_wstrb), 32'd0);
        check("rst.wdata", bus.data_wdata, 32'd0);
        check("rst.ram",   data_ram_rdata, 32'd0);
        ex_ls_ena = 1'b0; rst = 1'b0;
        step();

        run_access("lb",    LB,  32'h1000_0003, 32'h0,         32'h80FF_0011, 1'b0, 2'd0, 32'h1000_0003, 4'b0000, 32'h0,         32'h80FF_0011);
        run_access("swr1",  SWR, 32'h2000_0001, 32'hAABB_CCDD, 32'h5555_5555, 1'b1, 2'd2, 32'h2000_0000, 4'b1110, 32'hBBCC_DD00, 32'h80FF_0011);
        run_access("sb",    SB,  32'h0000_0106, 32'h1234_565A, 32'h0,         1'b1, 2'd0, 32'h0000_0106, 4'b0100, 32'h5A5A_5A5A, 32'h80FF_0011);
        run_access("sh_hi", SH,  32'h0000_0202, 32'h1111_BEEF, 32'h0,         1'b1, 2'd1, 32'h0000_0202, 4'b1100, 32'hBEEF_BEEF, 32'h80FF_0011);
        run_access("sh_lo", SH,  32'h0000_0700, 32'h0000_ABCD, 32'h0,         1'b1, 2'd1, 32'h0000_0700, 4'b0011, 32'hABCD_ABCD, 32'h80FF_0011);
        run_access("swl2",  SWL, 32'h0000_0302, 32'h1122_3344, 32'h0,         1'b1, 2'd2, 32'h0000_0300, 4'b0111, 32'h0011_2233, 32'h80FF_0011);
        run_access("swl0",  SWL, 32'h0000_0300, 32'h1122_3344, 32'h0,         1'b1, 2'd2, 32'h0000_0300, 4'b0001, 32'h0000_0011, 32'h80FF_0011);
        run_access("swr3",  SWR, 32'h0000_0303, 32'h1122_3344, 32'h0,         1'b1, 2'd2, 32'h0000_0300, 4'b1000, 32'h4400_0000, 32'h80FF_0011);
        run_access("sw",    SW,  32'h0000_0404, 32'hCAFE_BABE, 32'h0,         1'b1, 2'd2, 32'h0000_0404, 4'b1111, 32'hCAFE_BABE, 32'h80FF_0011);
        run_access("lhu",   LHU, 32'h0000_0502, 32'h0,         32'h0BAD_F00D, 1'b0, 2'd1, 32'h0000_0502, 4'b0000, 32'h0,         32'h0BAD_F00D);
        run_access("lwr",   LWR, 32'h0000_0603, 32'h0,         32'h600D_D00D, 1'b0, 2'd2, 32'h0000_0600, 4'b0000, 32'h0,         32'h600D_D00D);

        run_reject("lw_mis", LW, 32'h0000_0002, 1'b0, 1'b1, 1'b0);
        run_reject("lh_mis", LH, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        run_reject("sw_mis", SW, 32'h0000_0003, 1'b0, 1'b0, 1'b1);
        run_reject("sh_mis", SH, 32'h0000_0005, 1'b0, 1'b0, 1'b1);
        run_reject("exc",    LW, 32'h0000_0800, 1'b1, 1'b0, 1'b0);

        // Held request: addr_ok low for 5 cycles, fields stable for 6
        ex_ls_ena = 1'b1; ex_ls_sel = LW; ex_ls_addr = 32'h3000_0004;
        step();
        ex_ls_ena = 1'b0; ex_ls_sel = SB; ex_ls_addr = 32'hFFFF_FFFF;
        for (int i = 1; i <= 6; i++) begin
            bus.data_addr_ok = (i == 6);
            #1;
            check($sformatf("hold%0d.req", i),   32'(bus.data_req), 32'd1);
            check($sformatf("hold%0d.addr", i),  bus.data_addr, 32'h3000_0004);
            check($sformatf("hold%0d.size", i),  32'(bus.data_size), 32'd2);
            check($sformatf("hold%0d.wr", i),    32'(bus.data_wr), 32'd0);
            check($sformatf("hold%0d.stall", i), 32'(ls_stall), 32'd1);
            step();
        end
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D;
        #1;
        check("hold.stall_done", 32'(ls_stall), 32'd0);
        step();
        bus.data_data_ok = 1'b0;
        #1;
        check("hold.ram", data_ram_rdata, 32'hCAFE_F00D);

        // Flush in WAIT, response two cycles later
        ex_ls_ena = 1'b1; ex_ls_sel = LW; ex_ls_addr = 32'h4000_0000;
        step();
        ex_ls_ena = 1'b0; bus.data_addr_ok = 1'b1;
        step();
        bus.data_addr_ok = 1'b0; flush = 1'b1;
        #1;
        check("fw.stall_flush", 32'(ls_stall), 32'd1);
        check("fw.req_flush", 32'(bus.data_req), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("fw.stall_wait", 32'(ls_stall), 32'd1);
        step();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
        #1;
        check("fw.stall_ok", 32'(ls_stall), 32'd0);
        step();
        bus.data_data_ok = 1'b0;
        #1;
        check("fw.ram", data_ram_rdata, 32'hCAFE_F00D);
        check("fw.req", 32'(bus.data_req), 32'd0);
        step();
        check("fw.req2", 32'(bus.data_req), 32'd0);

        run_flush("f_addr", 32'h4000_0010, 1'b1, 1'b0, 32'h1111_1111, 32'hCAFE_F00D);
        run_flush("f_data", 32'h4000_0020, 1'b0, 1'b1, 32'h2222_2222, 32'hCAFE_F00D);

        // Stall after completion: HOLD freezes data and blocks accept
        ex_ls_ena = 1'b1; ex_ls_sel = LBU; ex_ls_addr = 32'h5000_0001;
        step();
        ex_ls_ena = 1'b0; bus.data_addr_ok = 1'b1;
        step();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0000_00AB; pipe_stall = 1'b1;
        #1;
        check("hs.stall_ok", 32'(ls_stall), 32'd0);
        step();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h9999_9999;
        ex_ls_ena = 1'b1; ex_ls_sel = LW; ex_ls_addr = 32'h6000_0000;
        #1;
        check("hs.ram_hold", data_ram_rdata, 32'h0000_00AB);
        check("hs.stall_hold", 32'(ls_stall), 32'd0);
        check("hs.req_hold", 32'(bus.data_req), 32'd0);
        step();
        pipe_stall = 1'b0;
        #1;
        check("hs.stall_release", 32'(ls_stall), 32'd0);
        step();
        check("hs.stall_idle", 32'(ls_stall), 32'd1);
        check("hs.ram_idle", data_ram_rdata, 32'h0000_00AB);
        step();
        ex_ls_ena = 1'b0; bus.data_addr_ok = 1'b1;
        #1;
        check("hs.req_next", 32'(bus.data_req), 32'd1);
        check("hs.addr_next", bus.data_addr, 32'h6000_0000);
        step();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h7777_7777;
        step();
        bus.data_data_ok = 1'b0;
        #1;
        check("hs.ram_next", data_ram_rdata, 32'h7777_7777);

        // Reset in the middle of a request
        ex_ls_ena = 1'b1; ex_ls_sel = LW; ex_ls_addr = 32'h7000_0000;
        step();
        ex_ls_ena = 1'b0;
        #1;
        check("mr.req_before", 32'(bus.data_req), 32'd1);
        rst = 1'b1;
        step();
        check("mr.req_rst", 32'(bus.data_req), 32'd0);
        check("mr.stall_rst", 32'(ls_stall), 32'd0);
        rst = 1'b0;
        step();
        check("mr.req_after", 32'(bus.data_req), 32'd0);
        check("mr.ram_after", data_ram_rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/data_req_ctrl.md
# data_req_ctrl

Data-side memory request controller in the EX→MEM boundary of the pipeline. It takes load/store operations from EX and checks alignment. It builds the byte strobes and lane-aligned write data, then runs the SRAM-like request/response handshake with the data memory. It holds the pipeline until the access completes and keeps the returned word stable for the load-alignment stage until the pipeline advances.

## Interface
- No parameters.
- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous reset, active-high.
- `ex_ls_ena` in 1: EX holds a load/store this cycle.
- `ex_ls_sel` in 4: operation, encoded with the `LS_SEL_*` macros from the decode definitions.
- `ex_ls_addr` in 32: effective address.
- `ex_rt_data` in 32: store source register.
- `ex_has_exception` in 1: an earlier exception is attached to the op; suppresses the access.
- `flush` in 1: pipeline flush from exception/eret commit.
- `pipe_stall` in 1: stall from all sources other than this block.
- `data_req` out 1: request valid.
- `data_wr` out 1: 1 = write.
- `data_size` out 2: 0 = byte, 1 = half, 2 = word.
- `data_addr` out 32: request address.
- `data_wstrb` out 4: byte strobes (4'b0000 for reads).
- `data_wdata` out 32: lane-aligned write data.
- `data_addr_ok` in 1: request accepted this cycle.
- `data_data_ok` in 1: response or write-ack this cycle.
- `data_rdata` in 32: read data, valid with `data_data_ok`.
- `ls_stall` out 1: hold IF/ID/EX.
- `data_ram_rdata` out 32: captured read word for the MEM stage.
- `is_data_adel` out 1: load address error.
- `is_data_ades` out 1: store address error.

## Operation
- **Accept.** An op is accepted when all of the following hold: `ex_ls_ena` is 1, `ex_has_exception` is 0, `flush` is 0, and the state is IDLE.
- **Address errors.** The address-error outputs are combinational from the EX inputs:
  - LH, LHU or SH with `ex_ls_addr[0]` = 1 → error.
  - LW or SW with `ex_ls_addr[1:0]` ≠ 0 → error.
  - ADEL is raised for loads, ADES for stores.
  - An erroring op issues no request.
- **Request fields.** These are latched into registers on accept:
  - LB/LBU/SB: size 0, full address.
  - LH/LHU/SH: size 1, full address.
  - LW/SW/LWL/LWR/SWL/SWR: size 2, address `{addr[31:2],2'b00}`.
- **Store data and strobes.**
  - SB: wdata `{4{rt[7:0]}}`, strobe `1 << addr[1:0]`.
  - SH: wdata `{2{rt[15:0]}}`, strobe 0011 (addr[1] = 0) or 1100 (addr[1] = 1).
  - SW: wdata rt, strobe 1111.
  - SWL by addr[1:0]:
    - 0: strobe 0001, wdata `{24'b0,rt[31:24]}`.
    - 1: strobe 0011, wdata `{16'b0,rt[31:16]}`.
    - 2: strobe 0111, wdata `{8'b0,rt[31:8]}`.
    - 3: strobe 1111, wdata rt.
  - SWR by addr[1:0]:
    - 0: strobe 1111, wdata rt.
    - 1: strobe 1110, wdata `{rt[23:0],8'b0}`.
    - 2: strobe 1100, wdata `{rt[15:0],16'b0}`.
    - 3: strobe 1000, wdata `{rt[7:0],24'b0}`.
- **FSM states.**
  - IDLE: on accept → REQ.
  - REQ: `data_req` = 1 and all fields held stable. On `data_addr_ok` → WAIT. A request is never withdrawn once raised.
  - WAIT: on `data_data_ok`:
    - If the killed flag is set → IDLE.
    - Else, for a read, capture `data_rdata` into `data_ram_rdata`.
    - Then → IDLE if `pipe_stall` = 0, else → HOLD.
  - HOLD: `data_ram_rdata` frozen. → IDLE when `pipe_stall` = 0.
- **Killed flag.**
  - Set by `flush` in REQ or WAIT.
  - Cleared on return to IDLE.
  - A killed access still completes its handshake, and its data is discarded.
- **`ls_stall`.**
  - High in IDLE on the accept cycle.
  - High throughout REQ and WAIT.
  - High in WAIT until the `data_data_ok` cycle, when it goes low.
  - Low in HOLD and IDLE otherwise.
- **One transaction outstanding at most.** A new accept is allowed only in IDLE.

## Timing
- **Reset.** State IDLE and killed flag cleared. The following outputs are 0:
  - `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata`.
  - `ls_stall`, `data_ram_rdata`.
  - `is_data_adel`, `is_data_ades` (these also stay 0 while `rst` is high).
- **Minimum latency** (accept at cycle 0):
  - `data_req` at cycle 1.
  - With `data_addr_ok` at cycle 1 and `data_data_ok` at cycle 2, `ls_stall` is high in cycles 0–1 and low at 2.
  - `data_ram_rdata` is valid from cycle 3.
- **Simultaneous events.**
  - `data_addr_ok` and `flush` in the same cycle → WAIT with killed set.
  - `data_data_ok` and `flush` in the same WAIT cycle → data discarded and `data_ram_rdata` unchanged.
- **Mid-transaction reset.** `rst` during REQ or WAIT returns to IDLE at once. The memory side is reset by the same `rst`.

## Test plan
- **LB.** LB, addr 0x1000_0003, addr_ok at cycle 1, data_ok at cycle 2 with rdata 0x80FF_0011.
  - Request: size 0, addr 0x1000_0003, wstrb 0000.
  - `ls_stall` high for 2 cycles.
  - `data_ram_rdata` = 0x80FF_0011 from cycle 3.
- **SWR.** SWR, addr 0x2000_0001, rt 0xAABB_CCDD.
  - Request: wr 1, addr 0x2000_0000, size 2, wstrb 1110, wdata 0xBBCC_DD00.
- **Misaligned LW.** LW, addr 0x0000_0002 → `is_data_adel` = 1, no `data_req`, `ls_stall` = 0.
- **Held request.** `data_addr_ok` held low for 5 cycles.
  - `data_req` and all fields stable for 6 cycles.
  - `ls_stall` high throughout.
- **Flush in WAIT.** `flush` in WAIT, data_ok 2 cycles later with rdata 0x1234_5678.
  - Returns to IDLE.
  - `data_ram_rdata` keeps its old value.
  - No second request.
- **Stall after completion.** `pipe_stall` high when data_ok arrives → HOLD with data frozen. `pipe_stall` drops → IDLE next cycle.
